// File: rtl/entity_sched_pkg.sv
// Shared constants and types for the entity slot scheduler.
// Entity word layout: [13:10] ID, [9:8] orientation, [7:0] tile.
package entity_sched_pkg;

    localparam int ENTITY_W = 14;

    localparam logic [ENTITY_W-1:0] ENTITY_UNUSED = 14'h3C00;

    localparam int ID_LSB     = 10;
    localparam int ID_MSB     = 13;
    localparam int ORIENT_LSB = 8;
    localparam int ORIENT_MSB = 9;
    localparam int TILE_LSB   = 0;
    localparam int TILE_MSB   = 7;

    typedef enum logic {
        RUN    = 1'b0,
        COMMIT = 1'b1
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant among req & ~mask,
// searching from ptr; ptr_next points just past the winner.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         mask,
    input  logic                 advance,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] ptr_next
);

    localparam int PW = $clog2(N);

    logic [N-1:0] eligible;
    logic [N-1:0] cand;

    assign eligible = req & ~mask;

    // Search downward so the lowest offset from ptr is the last one to win.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        grant    = '0;
        ptr_next = ptr;
        cand     = '0;
        if (advance) begin
            for (int k = N - 1; k >= 0; k--) begin
                cand = {{(N-1){1'b0}}, 1'b1} << ((int'(ptr) + k) % N);
                if (|(eligible & cand)) begin
                    grant    = cand;
                    ptr_next = PW'((((int'(ptr) + k) % N) + 1) % N);
                end
            end
        end
    end

endmodule

// File: rtl/entity_slot_scheduler.sv
// Round-robin entity writer for the frame-buffer controller with commit at vblank rise.
// Define ENTITY_SCHED_DBL_BUF_EN to stage writes in a shadow bank; otherwise writes go straight to live.
module entity_slot_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_SLOTS = 4,
    parameter int ENTITY_W  = entity_sched_pkg::ENTITY_W
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [NUM_REQ-1:0]                      req,
    input  logic [NUM_REQ*$clog2(NUM_SLOTS)-1:0]    req_slot,
    input  logic [NUM_REQ*ENTITY_W-1:0]             req_data,
    input  logic                                    vblank,
    output logic [NUM_REQ-1:0]                      gnt,
    output logic [NUM_SLOTS*ENTITY_W-1:0]           entity_out,
    output logic                                    pending,
    output logic                                    commit,
    output logic [7:0]                              frame_cnt
);

    import entity_sched_pkg::*;

    localparam int SW = $clog2(NUM_SLOTS);
    localparam int PW = $clog2(NUM_REQ);
    localparam logic [ENTITY_W-1:0] RST_WORD = ENTITY_W'(ENTITY_UNUSED);

    sched_state_e state, state_next;

    logic               vblank_q;
    logic               vblank_rise;
    logic               arb_advance;
    logic [NUM_REQ-1:0] arb_grant;
    logic [PW-1:0]      rr_ptr, rr_ptr_next;

    logic                wr_en;
    logic [SW-1:0]       wr_slot;
    logic [ENTITY_W-1:0] wr_data;

    logic [ENTITY_W-1:0] live [NUM_SLOTS];

    assign vblank_rise = vblank & ~vblank_q;
    assign commit      = (state == COMMIT);

    // The current grantee is masked so a held req becomes a fresh request next cycle.
    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .req      (req),
        .mask     (gnt),
        .advance  (arb_advance),
        .ptr      (rr_ptr),
        .grant    (arb_grant),
        .ptr_next (rr_ptr_next)
    );

    always_comb begin
        state_next  = state;
        arb_advance = 1'b0;
        unique case (state)
            RUN: begin
                if (vblank_rise) state_next  = COMMIT;
                else             arb_advance = 1'b1;
            end
            COMMIT: state_next = RUN;
        endcase
    end

    // frame_cnt steps on entry to COMMIT so it changes together with the commit pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            vblank_q  <= 1'b0;
            rr_ptr    <= '0;
            gnt       <= '0;
            frame_cnt <= '0;
        end else begin
            state    <= state_next;
            vblank_q <= vblank;
            rr_ptr   <= rr_ptr_next;
            gnt      <= arb_grant;
            if (state == RUN && vblank_rise) frame_cnt <= frame_cnt + 8'd1;
        end
    end

    always_comb begin
        wr_en   = |gnt;
        wr_slot = '0;
        wr_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                wr_slot = req_slot[i*SW +: SW];
                wr_data = req_data[i*ENTITY_W +: ENTITY_W];
            end
        end
    end

`ifdef ENTITY_SCHED_DBL_BUF_EN
    logic [ENTITY_W-1:0]  shadow [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] dirty;

    // No write can coincide with COMMIT: the grant that would feed it is suppressed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: both banks are reset because an unused slot must read ID 4'hF from the first frame.
            for (int s = 0; s < NUM_SLOTS; s++) begin
                live[s]   <= RST_WORD;
                shadow[s] <= RST_WORD;
            end
            dirty <= '0;
        end else if (state == COMMIT) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if (dirty[s]) live[s] <= shadow[s];
            end
            dirty <= '0;
        end else if (wr_en) begin
            shadow[wr_slot] <= wr_data;
            dirty[wr_slot]  <= 1'b1;
        end
    end

    assign pending = |dirty;
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                live[s] <= RST_WORD;
            end
        end else if (wr_en) begin
            live[wr_slot] <= wr_data;
        end
    end

    assign pending = 1'b0;
`endif

    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_out
        assign entity_out[s*ENTITY_W +: ENTITY_W] = live[s];
    end

endmodule

// File: tb/tb_entity_slot_scheduler.sv
// Directed bench for entity_slot_scheduler; expectations follow ENTITY_SCHED_DBL_BUF_EN.
module tb_entity_slot_scheduler;

    localparam int NUM_REQ   = 4;
    localparam int NUM_SLOTS = 4;
    localparam int ENTITY_W  = 14;
    localparam int SW        = 2;

`ifdef ENTITY_SCHED_DBL_BUF_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*SW-1:0]         req_slot;
    logic [NUM_REQ*ENTITY_W-1:0]   req_data;
    logic                          vblank;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_SLOTS*ENTITY_W-1:0] entity_out;
    logic                          pending;
    logic                          commit;
    logic [7:0]                    frame_cnt;

    int errors = 0;
    int checks = 0;

    logic [3:0] fair_exp [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
    logic [3:0] alt_exp  [4] = '{4'h1, 4'h4, 4'h1, 4'h4};

    entity_slot_scheduler #(
        .NUM_REQ   (NUM_REQ),
        .NUM_SLOTS (NUM_SLOTS),
        .ENTITY_W  (ENTITY_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_slot   (req_slot),
        .req_data   (req_data),
        .vblank     (vblank),
        .gnt        (gnt),
        .entity_out (entity_out),
        .pending    (pending),
        .commit     (commit),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [ENTITY_W-1:0] slot(input int s);
        return entity_out[s*ENTITY_W +: ENTITY_W];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [SW-1:0] s, input logic [ENTITY_W-1:0] d);
        req[i] = 1'b1;
        req_slot[i*SW +: SW] = s;
        req_data[i*ENTITY_W +: ENTITY_W] = d;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        req    = '0;
        vblank = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        req_slot = '0;
        req_data = '0;
        vblank   = 1'b0;
        tick();
        tick();

        // Reset state
        for (int s = 0; s < NUM_SLOTS; s++) check($sformatf("rst_slot%0d", s), 32'(slot(s)), 32'h3C00);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_commit", 32'(commit), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single write, then commit at vblank rise
        set_req(0, 2'd2, 14'h1A55);
        tick();
        check("single_gnt", 32'(gnt), 32'h1);
        req[0] = 1'b0;
        tick();
        check("single_gnt_drop", 32'(gnt), 32'h0);
        check("single_pending", 32'(pending), 32'(DBL));
        check("single_slot2_pre", 32'(slot(2)), DBL ? 32'h3C00 : 32'h1A55);
        tick();
        vblank = 1'b1;
        tick();
        check("single_commit", 32'(commit), 32'd1);
        check("single_frame_cnt", 32'(frame_cnt), 32'd1);
        check("single_slot2_commit_cycle", 32'(slot(2)), DBL ? 32'h3C00 : 32'h1A55);
        tick();
        check("single_slot2_post", 32'(slot(2)), 32'h1A55);
        check("single_commit_done", 32'(commit), 32'd0);
        check("single_pending_clr", 32'(pending), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("long_vblank_commit%0d", k), 32'(commit), 32'd0);
        end
        check("long_vblank_frame_cnt", 32'(frame_cnt), 32'd1);
        vblank = 1'b0;
        tick();

        // Fairness: four requesters held high
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, SW'(i), 14'(14'h0100 + i));
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("fair_gnt%0d", k), 32'(gnt), 32'(fair_exp[k]));
        end
        req = '0;
        tick();

        // Two requesters alternate
        do_reset();
        set_req(0, 2'd0, 14'h0100);
        set_req(2, 2'd2, 14'h0200);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("alt_gnt%0d", k), 32'(gnt), 32'(alt_exp[k]));
        end
        req = '0;
        tick();

        // Overwrite: last grant to a slot wins
        do_reset();
        set_req(1, 2'd0, 14'h0011);
        tick();
        check("ovw_gnt1", 32'(gnt), 32'h2);
        req[1] = 1'b0;
        tick();
        set_req(2, 2'd0, 14'h0022);
        tick();
        check("ovw_gnt2", 32'(gnt), 32'h4);
        req[2] = 1'b0;
        tick();
        check("ovw_pending", 32'(pending), 32'(DBL));
        check("ovw_slot0_pre", 32'(slot(0)), DBL ? 32'h3C00 : 32'h0022);
        vblank = 1'b1;
        tick();
        tick();
        check("ovw_slot0_post", 32'(slot(0)), 32'h0022);
        check("ovw_frame_cnt", 32'(frame_cnt), 32'd1);
        vblank = 1'b0;
        tick();

        // Vblank collision: request arrives in the rise cycle
        do_reset();
        set_req(3, 2'd3, 14'h2B33);
        vblank = 1'b1;
        tick();
        check("coll_gnt_commit_cycle", 32'(gnt), 32'h0);
        check("coll_commit", 32'(commit), 32'd1);
        tick();
        check("coll_gnt_first_run", 32'(gnt), 32'h0);
        check("coll_commit_done", 32'(commit), 32'd0);
        tick();
        check("coll_gnt3", 32'(gnt), 32'h8);
        req[3] = 1'b0;
        tick();
        check("coll_slot3_pre", 32'(slot(3)), DBL ? 32'h3C00 : 32'h2B33);
        check("coll_pending", 32'(pending), 32'(DBL));
        vblank = 1'b0;
        tick();
        vblank = 1'b1;
        tick();
        check("coll_frame_cnt", 32'(frame_cnt), 32'd2);
        tick();
        check("coll_slot3_post", 32'(slot(3)), 32'h2B33);
        vblank = 1'b0;
        tick();

        // Grant issued in the rise cycle completes and joins this commit
        do_reset();
        set_req(0, 2'd1, 14'h1234);
        tick();
        check("late_gnt0", 32'(gnt), 32'h1);
        req[0] = 1'b0;
        vblank = 1'b1;
        tick();
        check("late_commit", 32'(commit), 32'd1);
        check("late_gnt_none", 32'(gnt), 32'h0);
        tick();
        check("late_slot1", 32'(slot(1)), 32'h1234);
        check("late_pending", 32'(pending), 32'd0);
        vblank = 1'b0;
        tick();

        // Reset mid-frame discards staged data and restarts frame_cnt
        do_reset();
        vblank = 1'b1;
        tick();
        check("midrst_frame_cnt_pre", 32'(frame_cnt), 32'd1);
        vblank = 1'b0;
        tick();
        set_req(1, 2'd1, 14'h0F0F);
        tick();
        check("midrst_gnt1", 32'(gnt), 32'h2);
        req[1] = 1'b0;
        tick();
        check("midrst_pending", 32'(pending), 32'(DBL));
        set_req(2, 2'd3, 14'h1111);
        tick();
        check("midrst_gnt2", 32'(gnt), 32'h4);
        rst_n = 1'b0;
        req   = '0;
        tick();
        check("midrst_gnt_drop", 32'(gnt), 32'h0);
        check("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("midrst_pending_clr", 32'(pending), 32'd0);
        rst_n = 1'b1;
        tick();
        vblank = 1'b1;
        tick();
        check("midrst_frame_cnt_post", 32'(frame_cnt), 32'd1);
        check("midrst_commit", 32'(commit), 32'd1);
        tick();
        check("midrst_slot1", 32'(slot(1)), 32'h3C00);
        check("midrst_slot3", 32'(slot(3)), 32'h3C00);
        vblank = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
